// File: rtl/mont_exp_ctrl_pkg.sv
// Shared encodings for the modular-exponentiation sequencer.
package mont_exp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FINISH
  } state_t;

  typedef enum logic [1:0] {
    OP_CONV,
    OP_SQR,
    OP_MUL,
    OP_OUT
  } op_t;

  // exp_len must be able to hold every value 0..exp_width inclusive
  function automatic int len_bits(input int exp_width);
    return $clog2(exp_width + 1);
  endfunction

endpackage

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one Montgomery multiplier.
// Computes X^E mod M entirely through multiplier operations; no arithmetic here.
module mont_exp_ctrl
  import mont_exp_ctrl_pkg::*;
#(
  parameter int WIDTH     = 512,
  parameter int EXP_WIDTH = 512,
  parameter int LEN_W     = len_bits(EXP_WIDTH)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [LEN_W-1:0]     exp_len,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r,
  input  logic [WIDTH-1:0]     in_r2,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_m,
  input  logic [WIDTH-1:0]     mm_result,
  input  logic                 mm_done,
  output logic                 busy,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output state_t               dbg_state
);

  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  // Handshake: a command is taken when start=1 in IDLE; busy stays high until the
  // one-cycle done pulse. Toward the multiplier, mm_start is a one-cycle pulse with
  // mm_a/mm_b/mm_m stable until the matching one-cycle mm_done, which is only
  // honoured in WAIT.
  state_t                 state;
  op_t                    op;
  logic [WIDTH-1:0]       x_q;
  logic [WIDTH-1:0]       r2_q;
  logic [EXP_WIDTH-1:0]   e_q;
  logic [LEN_W-1:0]       len_q;
  logic [IDX_W-1:0]       idx;
  logic [WIDTH-1:0]       acc;
  logic [WIDTH-1:0]       xm;
  logic [LEN_W-1:0]       len_c;

  assign len_c     = (exp_len > LEN_W'(EXP_WIDTH)) ? LEN_W'(EXP_WIDTH) : exp_len;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      op       <= OP_CONV;
      idx      <= '0;
      x_q      <= '0;
      r2_q     <= '0;
      e_q      <= '0;
      len_q    <= '0;
      acc      <= '0;
      xm       <= '0;
      mm_start <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
      mm_m     <= '0;
      busy     <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
    end else begin
      mm_start <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            x_q   <= in_x;
            e_q   <= in_e;
            len_q <= len_c;
            mm_m  <= in_m;
            r2_q  <= in_r2;
            acc   <= in_r;
            idx   <= IDX_W'(len_c - 1'b1);
            op    <= OP_CONV;
            busy  <= 1'b1;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mm_start <= 1'b1;
          unique case (op)
            OP_CONV: begin mm_a <= x_q; mm_b <= r2_q; end
            OP_SQR:  begin mm_a <= acc; mm_b <= acc;  end
            OP_MUL:  begin mm_a <= acc; mm_b <= xm;   end
            OP_OUT:  begin mm_a <= acc; mm_b <= {{(WIDTH-1){1'b0}}, 1'b1}; end
          endcase
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mm_done) begin
            state <= ST_ISSUE;
            unique case (op)
              OP_CONV: begin
                xm <= mm_result;
                op <= (len_q != '0) ? OP_SQR : OP_OUT;
              end
              OP_SQR: begin
                acc <= mm_result;
                if (e_q[idx])       op <= OP_MUL;
                else if (idx != '0) begin idx <= idx - 1'b1; op <= OP_SQR; end
                else                op <= OP_OUT;
              end
              OP_MUL: begin
                acc <= mm_result;
                // bit 0 done means the loop is exhausted; idx never wraps
                if (idx != '0) begin idx <= idx - 1'b1; op <= OP_SQR; end
                else           op <= OP_OUT;
              end
              OP_OUT: begin
                acc   <= mm_result;
                state <= ST_FINISH;
              end
            endcase
          end
        end
        ST_FINISH: begin
          result <= acc;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: behavioural Montgomery multiplier with configurable
// latency, plain-arithmetic reference for operand order and X^E mod M.
module tb_mont_exp_ctrl;
  import mont_exp_ctrl_pkg::*;

  localparam int W      = 512;
  localparam int EW     = 512;
  localparam int LW     = 10;
  localparam int BUDGET = 20000;

  logic          clk;
  logic          resetn;
  logic          start;
  logic [W-1:0]  in_x;
  logic [EW-1:0] in_e;
  logic [LW-1:0] exp_len;
  logic [W-1:0]  in_m;
  logic [W-1:0]  in_r;
  logic [W-1:0]  in_r2;
  logic          mm_start;
  logic [W-1:0]  mm_a;
  logic [W-1:0]  mm_b;
  logic [W-1:0]  mm_m;
  logic [W-1:0]  mm_result;
  logic          mm_done;
  logic          busy;
  logic [W-1:0]  result;
  logic          done;
  state_t        dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];

  mont_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW), .LEN_W(LW)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_e(in_e), .exp_len(exp_len), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done),
    .busy(busy), .result(result), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- arithmetic helpers ----------------
  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] m);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    p = p % {{W{1'b0}}, m};
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] rmod(input logic [W-1:0] m);
    logic [2*W-1:0] t;
    t    = '0;
    t[W] = 1'b1;
    t    = t % {{W{1'b0}}, m};
    return t[W-1:0];
  endfunction

  // right-to-left binary power, independent of the sequencer's bit order
  function automatic logic [W-1:0] powmod(input logic [W-1:0] x, input logic [EW-1:0] e,
                                          input int len, input logic [W-1:0] m);
    logic [W-1:0] p;
    logic [W-1:0] b;
    p = mulmod(W'(1), W'(1), m);
    b = x;
    for (int i = 0; i < len; i++) begin
      if (e[i]) p = mulmod(p, b, m);
      b = mulmod(b, b, m);
    end
    return p;
  endfunction

  // radix-2 Montgomery product a*b*2^-W mod m
  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] m);
    logic [W+1:0] t;
    t = '0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- behavioural multiplier ----------------
  int           lmm_cfg = 1;
  int           mm_cnt  = 0;
  logic         inject;
  logic [W-1:0] mm_res_q;

  always @(posedge clk) begin
    if (mm_start) begin
      mm_cnt   <= lmm_cfg;
      mm_res_q <= mont(mm_a, mm_b, mm_m);
    end else if (mm_cnt > 0) begin
      mm_cnt <= mm_cnt - 1;
    end
  end
  assign mm_done   = (mm_cnt == 1) || inject;
  assign mm_result = mm_res_q;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected multiplier operands. The accumulator holds p*R mod M where p is the
  // plain partial power, so each expected operand is derived from p directly.
  task automatic build_ops(input logic [W-1:0] x, input logic [EW-1:0] e, input int len,
                           input logic [W-1:0] m, input logic [W-1:0] r, input logic [W-1:0] r2);
    logic [W-1:0] p;
    logic [W-1:0] acc_m;
    logic [W-1:0] x_m;
    exp_a_q.delete();
    exp_b_q.delete();
    exp_a_q.push_back(x);
    exp_b_q.push_back(r2);
    x_m = mulmod(x, r, m);
    p   = mulmod(W'(1), W'(1), m);
    for (int i = len - 1; i >= 0; i--) begin
      acc_m = mulmod(p, r, m);
      exp_a_q.push_back(acc_m);
      exp_b_q.push_back(acc_m);
      p = mulmod(p, p, m);
      if (e[i]) begin
        acc_m = mulmod(p, r, m);
        exp_a_q.push_back(acc_m);
        exp_b_q.push_back(x_m);
        p = mulmod(p, x, m);
      end
    end
    exp_a_q.push_back(mulmod(p, r, m));
    exp_b_q.push_back(W'(1));
  endtask

  // ---------------- driver / monitor for one exponentiation ----------------
  task automatic run_exp(input logic [W-1:0] x, input logic [EW-1:0] e, input logic [LW-1:0] len,
                         input logic [W-1:0] m, input int lmm, input int exp_starts,
                         input bit poke_busy, input bit poke_issue, input int reset_at);
    logic [W-1:0] r, r2, want, ca, cb, res_hold;
    int eff_len, n_mm, starts, k, pulses;
    bit seen_done, waiting;

    r       = rmod(m);
    r2      = mulmod(r, r, m);
    eff_len = (int'(len) > EW) ? EW : int'(len);
    build_ops(x, e, eff_len, m, r, r2);
    want = powmod(x, e, eff_len, m);
    n_mm = 2 + eff_len;
    for (int i = 0; i < eff_len; i++) n_mm += int'(e[i]);
    lmm_cfg = lmm;

    @(negedge clk);
    start = 1'b1; in_x = x; in_e = e; exp_len = len; in_m = m; in_r = r; in_r2 = r2;
    @(negedge clk);
    check("busy_after_accept", W'(busy), W'(1));
    starts = 0; seen_done = 0; waiting = 0; ca = '0; cb = '0;

    for (k = 0; k < BUDGET; k++) begin
      if (k > 0) @(negedge clk);
      inject = (poke_issue && k == 0);
      if (poke_busy && k == 5) begin
        start = 1'b1;
        in_x  = x ^ W'(2);
      end else begin
        start = 1'b0;
      end
      if (k == reset_at) begin
        inject = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check("rst_mm_start", W'(mm_start), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_result", result, W'(0));
        check("rst_mm_a", mm_a, W'(0));
        check("rst_mm_b", mm_b, W'(0));
        check("rst_mm_m", mm_m, W'(0));
        check("rst_state", W'(dbg_state), W'(ST_IDLE));
        @(negedge clk);
        resetn = 1'b1;
        pulses = 0;
        repeat (30) begin
          @(negedge clk);
          if (done || mm_start || busy) pulses++;
        end
        check("rst_no_pulse_after_release", W'(pulses), W'(0));
        check("rst_idle_after_release", W'(dbg_state), W'(ST_IDLE));
        return;
      end
      if (mm_start) begin
        if (exp_a_q.size() == 0) begin
          check("extra_mm_start", W'(starts + 1), W'(n_mm));
        end else begin
          check("mm_a_order", mm_a, exp_a_q.pop_front());
          check("mm_b_order", mm_b, exp_b_q.pop_front());
        end
        check("mm_m_value", mm_m, m);
        starts++;
        ca = mm_a; cb = mm_b; waiting = 1;
      end
      if (mm_done && waiting) begin
        check("mm_a_stable", mm_a, ca);
        check("mm_b_stable", mm_b, cb);
        waiting = 0;
      end
      if (done) begin
        seen_done = 1;
        break;
      end
    end

    check("done_seen", W'(seen_done), W'(1));
    check("result", result, want);
    check("latency", W'(k), W'(1 + n_mm * (2 + lmm)));
    check("mm_start_count", W'(starts), W'((exp_starts >= 0) ? exp_starts : n_mm));
    check("ops_left", W'(exp_a_q.size()), W'(0));
    check("busy_at_done", W'(busy), W'(0));
    res_hold = result;
    @(negedge clk);
    check("done_one_cycle", W'(done), W'(0));
    // stray completion while idle must not disturb anything
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    @(negedge clk);
    check("idle_stray_done_busy", W'(busy), W'(0));
    check("idle_stray_done_done", W'(done), W'(0));
    check("idle_stray_state", W'(dbg_state), W'(ST_IDLE));
    check("result_held", result, res_hold);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [W-1:0]  m_rand;
    logic [W-1:0]  x_rand;
    logic [EW-1:0] e_rand;

    resetn = 1'b0; start = 1'b0; inject = 1'b0;
    in_x = '0; in_e = '0; exp_len = '0; in_m = '0; in_r = '0; in_r2 = '0;
    #1;
    check("reset_mm_start", W'(mm_start), W'(0));
    check("reset_busy", W'(busy), W'(0));
    check("reset_done", W'(done), W'(0));
    check("reset_result", result, W'(0));
    check("reset_mm_m", mm_m, W'(0));
    check("reset_state", W'(dbg_state), W'(ST_IDLE));
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // 5^3 mod 241 = 125, six multiplier ops, done 73 cycles after acceptance
    run_exp(W'(5), EW'(3), LW'(2), W'(241), 10, 6, 1'b0, 1'b0, -1);
    check("tp1_value", result, W'(125));
    // 2^13 mod 241 = 239, nine ops in order CONV,SQR,MUL,SQR,MUL,SQR,SQR,MUL,OUT
    run_exp(W'(2), EW'(13), LW'(4), W'(241), 3, 9, 1'b0, 1'b0, -1);
    check("tp2_value", result, W'(239));
    // empty exponent gives 1 mod M with just conversion and output
    run_exp(W'(7), EW'(0), LW'(0), W'(241), 2, 2, 1'b0, 1'b0, -1);
    check("tp3_value", result, W'(1));
    // start during WAIT and a stray mm_done during ISSUE are both ignored
    run_exp(W'(5), EW'(3), LW'(2), W'(241), 10, 6, 1'b1, 1'b1, -1);
    check("tp4_value", result, W'(125));
    // abort mid-WAIT, then a fresh run
    run_exp(W'(11), EW'(45), LW'(6), W'(241), 10, -1, 1'b0, 1'b0, 8);
    run_exp(W'(3), EW'(255), LW'(8), W'(241), 1, 18, 1'b0, 1'b0, -1);

    // full width, random operands
    m_rand = rand_w(); m_rand[W-1] = 1'b1; m_rand[0] = 1'b1;
    x_rand = rand_w(); x_rand[W-1] = 1'b0;
    e_rand = rand_w();
    run_exp(x_rand, e_rand, LW'(512), m_rand, $urandom_range(1, 4), -1, 1'b0, 1'b0, -1);

    // exp_len above EXP_WIDTH is clamped
    m_rand = rand_w(); m_rand[W-1] = 1'b1; m_rand[0] = 1'b1;
    x_rand = rand_w(); x_rand[W-1] = 1'b0;
    e_rand = rand_w();
    run_exp(x_rand, e_rand, LW'(700), m_rand, $urandom_range(1, 3), -1, 1'b0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mont_exp_ctrl.md
Name: mont_exp_ctrl

Overview:
- Modular-exponentiation sequencer. Computes result = X^E mod M by left-to-right square-and-multiply.
- Initiator side of the montgomery multiplier start/done handshake. It drives operands and a start pulse, waits for done, and captures the product.
- Sits between the top-level command/IO logic and one montgomery multiplier instance. It owns all operand sequencing; the multiplier stays a pure start/done slave.

Parameters:
- WIDTH, 512, operand/modulus width in bits.
- EXP_WIDTH, 512, exponent register width in bits.
- LEN_W, 10, width of exp_len; must hold values 0..EXP_WIDTH.

Ports:
- clk  in  1  clock; all flops rising-edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- in_x  in  WIDTH  base X, X < M.
- in_e  in  EXP_WIDTH  exponent E.
- exp_len  in  LEN_W  number of exponent bits processed, taken from the MSB end at exp_len-1.
- in_m  in  WIDTH  odd modulus M.
- in_r  in  WIDTH  R mod M, with R = 2^WIDTH.
- in_r2  in  WIDTH  R^2 mod M.
- mm_start  out  1  one-cycle start pulse to the multiplier.
- mm_a  out  WIDTH  multiplier operand A.
- mm_b  out  WIDTH  multiplier operand B.
- mm_m  out  WIDTH  modulus to the multiplier.
- mm_result  in  WIDTH  multiplier product; valid in the cycle mm_done=1.
- mm_done  in  1  multiplier completion pulse.
- busy  out  1  high from start acceptance until done.
- result  out  WIDTH  X^E mod M; held until the next accepted start.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE. mm_start=0, done=0, busy=0, result=0, mm_a=mm_b=mm_m=0. Bit counter=0 and op=OP_CONV.
  - Reset mid-operation aborts immediately. No pulse is emitted on release.
  - The multiplier is not reset by this block; a stale mm_done arriving after release lands in IDLE and is ignored.
- Start acceptance (IDLE and start=1):
  - Register x, e, exp_len, m, r, r2.
  - Set acc=r, bit index i=exp_len-1, op=OP_CONV, busy=1. Go to ISSUE.
  - start while busy is ignored, with no effect on registered operands.
- State machine (IDLE, ISSUE, WAIT, FINISH):
  - ISSUE: mm_start=1 for exactly one cycle, with mm_a/mm_b already driven for the current op. Go to WAIT.
  - WAIT: mm_a, mm_b, mm_m held stable. On mm_done=1, capture mm_result into the op's destination and choose the next op (below). Go to ISSUE, or to FINISH after OP_OUT.
  - FINISH: result=acc, done=1 for one cycle, busy=0. Go to IDLE.
  - mm_done outside WAIT is ignored.
- Ops (operands → destination):
  - OP_CONV: a=x, b=r2 → xm.
  - OP_SQR: a=acc, b=acc → acc.
  - OP_MUL: a=acc, b=xm → acc.
  - OP_OUT: a=acc, b=1 (zero-extended) → acc.
- Next-op rule:
  - After OP_CONV: OP_SQR if exp_len>0, else OP_OUT.
  - After OP_SQR: OP_MUL if e[i]=1. Otherwise decrement i; then OP_SQR if more bits remain, else OP_OUT.
  - After OP_MUL: decrement i; then OP_SQR if more bits remain, else OP_OUT.
  - Bit i=0 processed means the loop is exhausted; there is no wrap of i below 0.
- exp_len=0: only OP_CONV and OP_OUT run; result = 1 mod M.
- exp_len>EXP_WIDTH is clamped to EXP_WIDTH at acceptance.
- Operation count: N_mm = 2 + exp_len + popcount(e[exp_len-1:0]).
- Latency: done occurs 1 + N_mm*(2+Lmm) cycles after the start-acceptance edge. Lmm is the number of cycles from the mm_start edge to the mm_done cycle. The "+1" accounts for FINISH.
- mm_m = m, held for the whole operation.
- No arithmetic is performed in this block; all reduction happens in the multiplier.

Decomposition:
- Shared package: state encoding (IDLE, ISSUE, WAIT, FINISH), op encoding (OP_CONV, OP_SQR, OP_MUL, OP_OUT), and the LEN_W derivation.
- No sub-module. An operand mux plus one FSM is natural in a single module. The bench pairs it with the montgomery multiplier or a behavioural model with configurable Lmm.

Test Plan:
- x=5, e=3, exp_len=2, M=241, r/r2 computed by bench, model Lmm=10 → result=125. Exactly 6 mm_start pulses. done 73 cycles after acceptance.
- x=2, e=0xD, exp_len=4, M=241 → result=239. 9 mm_start pulses. Op order: CONV,SQR,MUL,SQR,MUL,SQR,SQR,MUL,OUT.
- exp_len=0, x=7, M=241 → result=1, 2 mm_start pulses, done once.
- Busy start: a second start with different in_x during WAIT is ignored, giving the same result as the first. A spurious mm_done in ISSUE/IDLE produces no state change.
- Reset: resetn low for 1 cycle mid-WAIT → all outputs 0 asynchronously and no done. A fresh start then with x=3, e=0xFF, exp_len=8, M=241 → result=3^255 mod 241 (bench-computed).
- Full width: random 512-bit odd M, x<M, e random, exp_len=512 with the real montgomery multiplier → matches the bench bigint pow. Operands stay stable through every WAIT.
